// File: rtl/uart_byte_tx.sv
// Byte-wide UART transmitter: 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined.
// Every output is a registered function of the state the FSM is in, so the line lags the state by one cycle.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_tx_go,
  input  logic [7:0] out_byte,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_CLEANUP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_serial;
  logic          r_active;
  logic          r_done;

  logic w_bit_end;
  assign w_bit_end = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_serial <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_serial <= 1'b1;
          r_active <= 1'b0;
          r_cnt    <= '0;
          if (uart_tx_go) begin
            r_shift <= out_byte;
            r_bit   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_serial <= 1'b0;
          r_active <= 1'b1;
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          r_serial <= r_shift[r_bit];
          r_active <= 1'b1;
          if (w_bit_end) begin
            r_cnt <= '0;
            r_bit <= r_bit + 1'b1;  // wraps back to 0 after bit 7
            if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          r_serial <= ^r_shift;
          r_active <= 1'b1;
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          r_serial <= 1'b1;
          r_active <= 1'b1;
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_CLEANUP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CLEANUP: begin
          r_serial <= 1'b1;
          r_active <= 1'b0;
          r_done   <= 1'b1;
          r_cnt    <= '0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_serial = r_serial;
  assign o_tx_active = r_active;
  assign tx_done     = r_done;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at CLKS_PER_BIT=4; follows UART_TX_PARITY_EN for the frame length.
module tb_uart_byte_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go  = 1'b0;
  logic [7:0] ob  = 8'h00;
  wire        ser, act, done;

  uart_byte_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_tx_go (go),
    .out_byte   (ob),
    .o_tx_serial(ser),
    .o_tx_active(act),
    .tx_done    (done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, ndone = 0, cyc = 0, last_done = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) ndone++;

  typedef struct {
    logic [7:0] d;
    logic       par;   // hand-computed even parity
    bit         poke;  // disturb out_byte / uart_tx_go mid-frame and in CLEANUP
  } vec_t;
  vec_t tv[6];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ser", ser, 1);
      chk("idle_act", act, 0);
      chk("idle_done", done, 0);
    end
  endtask

  // Caller has set go/ob at the current negedge; the next posedge accepts the request.
  task automatic frame(input logic [7:0] d, input logic par, input bit poke,
                       input bit hold, input logic [7:0] nxt);
    logic [10:0] bits;
    bits = '1;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = d[k];
    bits[9] = (NB == 11) ? par : 1'b1;
    @(negedge clk);
    if (hold) ob = nxt; else go = 1'b0;
    chk("pre_start_ser", ser, 1);
    for (int i = 0; i < NB * CPB; i++) begin
      @(negedge clk);
      chk($sformatf("line_%02h_c%0d", d, i), ser, bits[i/CPB]);
      chk("frame_act", act, 1);
      chk("frame_done", done, 0);
      if (poke && i == 10) begin ob = 8'hFF; go = 1'b1; end
      if (poke && i == 11) go = 1'b0;
      if (poke && i == NB * CPB - 1) go = 1'b1;
    end
    @(negedge clk);
    if (poke) go = 1'b0;
    chk($sformatf("done_%02h", d), done, 1);
    chk("cleanup_ser", ser, 1);
    chk("cleanup_act", act, 0);
    last_done = cyc;
  endtask

  initial begin
    int t1, nd0;
    tv[0] = '{8'h41, 1'b0, 1'b0};
    tv[1] = '{8'h43, 1'b1, 1'b0};
    tv[2] = '{8'h55, 1'b0, 1'b1};
    tv[3] = '{8'h00, 1'b0, 1'b0};
    tv[4] = '{8'hFF, 1'b0, 1'b0};
    tv[5] = '{8'h80, 1'b1, 1'b0};

    // reset, with a request asserted that must be dropped
    go = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ser", ser, 1);
    chk("rst_act", act, 0);
    chk("rst_done", done, 0);
    go = 1'b0;
    rst = 1'b0;
    idle_chk(20);

    for (int v = 0; v < 6; v++) begin
      go = 1'b1;
      ob = tv[v].d;
      frame(tv[v].d, tv[v].par, tv[v].poke, 1'b0, 8'h00);
      idle_chk(10);
    end
    chk("done_count_table", ndone, 6);

    // back-to-back with uart_tx_go held high
    go = 1'b1;
    ob = 8'h30;
    frame(8'h30, 1'b0, 1'b0, 1'b1, 8'h31);
    t1 = last_done;
    frame(8'h31, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("b2b_spacing", last_done - t1, NB * CPB + 2);
    idle_chk(5);

    // reset during data bit 3 of 0xA5, with a simultaneous request
    nd0 = ndone;
    go = 1'b1;
    ob = 8'hA5;
    @(negedge clk);
    go = 1'b0;
    repeat (18) @(negedge clk);
    chk("bit3_ser", ser, 0);  // bit 3 of 0xA5 is 0
    chk("bit3_act", act, 1);
    rst = 1'b1;
    go = 1'b1;
    @(negedge clk);
    chk("abort_ser", ser, 1);
    chk("abort_act", act, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    go = 1'b0;
    idle_chk(50);
    chk("abort_no_done", ndone, nd0);

    go = 1'b1;
    ob = 8'h5A;
    frame(8'h5A, 1'b0, 1'b0, 1'b0, 8'h00);
    idle_chk(5);
    chk("done_count_total", ndone, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
